// File: rtl/sd_resp_rx_if.sv
// Handshake and status bundle between the host command FSM and the
// short-response receiver.
interface sd_resp_rx_if;
    logic        rx_en;
    logic        check_crc;
    logic        check_index;
    logic [5:0]  exp_index;
    logic        sd_cmd;
    logic [37:0] resp_content;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic        crc_err;
    logic        frame_err;
    logic        index_err;

    modport master (
        output rx_en, check_crc, check_index, exp_index, sd_cmd,
        input  resp_content, busy, done, timeout_err, crc_err, frame_err, index_err
    );

    modport slave (
        input  rx_en, check_crc, check_index, exp_index, sd_cmd,
        output resp_content, busy, done, timeout_err, crc_err, frame_err, index_err
    );
endinterface

// File: rtl/sd_resp_rx.sv
// SD 48-bit short response receiver: waits for the start bit, shifts in the
// frame, checks CRC7/framing/index and presents the 38-bit content.
module sd_resp_rx #(
    parameter int TIMEOUT = 64
) (
    input logic         clk,
    input logic         reset,
    sd_resp_rx_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT_START, RECEIVE, DONE} state_t;

    state_t      state;
    logic [TW-1:0] timer;
    logic [5:0]  bit_cnt;
    logic [6:0]  crc;
    logic [37:0] shift;
    logic        chk_crc;
    logic        chk_idx;
    logic [5:0]  exp_idx;

    logic        d;
    logic        fb;
    logic [6:0]  crc_nx;
    logic [2:0]  crc_idx;

    assign d       = bus.sd_cmd;
    assign fb      = d ^ crc[6];
    assign crc_nx  = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    // frame bits 7..1 carry crc[6]..crc[0], MSB first
    assign crc_idx = bit_cnt[2:0] - 3'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            timer            <= '0;
            bit_cnt          <= '0;
            crc              <= '0;
            shift            <= '0;
            chk_crc          <= 1'b0;
            chk_idx          <= 1'b0;
            exp_idx          <= '0;
            bus.resp_content <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.timeout_err  <= 1'b0;
            bus.crc_err      <= 1'b0;
            bus.frame_err    <= 1'b0;
            bus.index_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.rx_en) begin
                        state           <= WAIT_START;
                        bus.busy        <= 1'b1;
                        chk_crc         <= bus.check_crc;
                        chk_idx         <= bus.check_index;
                        exp_idx         <= bus.exp_index;
                        timer           <= '0;
                        crc             <= '0;
                        bus.timeout_err <= 1'b0;
                        bus.crc_err     <= 1'b0;
                        bus.frame_err   <= 1'b0;
                        bus.index_err   <= 1'b0;
                    end
                end
                WAIT_START: begin
                    // a start bit on the last allowed cycle still wins
                    if (!d) begin
                        state   <= RECEIVE;
                        crc     <= crc_nx;
                        bit_cnt <= 6'd46;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        state           <= DONE;
                        bus.done        <= 1'b1;
                        bus.timeout_err <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RECEIVE: begin
                    bit_cnt <= bit_cnt - 6'd1;
                    if (bit_cnt >= 6'd8) begin
                        shift <= {shift[36:0], d};
                        crc   <= crc_nx;
                        if (bit_cnt == 6'd46 && d) bus.frame_err <= 1'b1;
                    end else if (bit_cnt != 6'd0) begin
                        if (chk_crc && (d != crc[crc_idx])) bus.crc_err <= 1'b1;
                    end else begin
                        if (!d) bus.frame_err <= 1'b1;
                        if (chk_idx && (shift[37:32] != exp_idx)) bus.index_err <= 1'b1;
                        bus.resp_content <= shift;
                        bus.done         <= 1'b1;
                        state            <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_resp_rx.sv
// Randomized bench for sd_resp_rx: a cycle-timeline reference model built
// from frame contents, checked every cycle, plus directed literal cases.
module tb_sd_resp_rx;
    localparam int T = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sd_resp_rx_if bus ();

    sd_resp_rx #(.TIMEOUT(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // reference timeline: busy window, done cycle, final results
    int          b_lo = -10, b_hi = -10, done_cyc = -10;
    int          done_seen = -10;
    int          last_rx = 0;
    logic [37:0] exp_content = '0;
    logic [37:0] prev_content = '0;
    logic [3:0]  exp_flags = '0;   // {timeout, crc, frame, index}
    logic        mon_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // remainder of m(x)*x^7 divided by x^7+x^3+1 (long division)
    function automatic logic [6:0] crc7(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r = r ^ (47'h89 << (i - 7));
        return r[6:0];
    endfunction

    function automatic logic [47:0] mk(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b00, idx, arg, crc7({2'b00, idx, arg}), 1'b1};
    endfunction

    function automatic logic [3:0] flags();
        return {bus.timeout_err, bus.crc_err, bus.frame_err, bus.index_err};
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            chk("busy", 64'(bus.busy), 64'(cyc >= b_lo && cyc <= b_hi));
            chk("done", 64'(bus.done), 64'(cyc == done_cyc));
            if (bus.done) done_seen = cyc;
            if (cyc == done_cyc || cyc > b_hi) begin
                chk("content", 64'(bus.resp_content), 64'(exp_content));
                chk("flags", 64'(flags()), 64'(exp_flags));
            end else if (cyc >= b_lo) begin
                chk("content_hold", 64'(bus.resp_content), 64'(prev_content));
                if (cyc == b_lo) chk("flags_cleared", 64'(flags()), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One armed receive. dly >= T means no start bit (timeout).
    task automatic run(input logic [47:0] f, input int dly, input logic cc, input logic ci,
                       input logic [5:0] ei, input int abort_bit, input logic rx_mid,
                       input logic rx_at_done);
        int k;
        int s;
        tick();
        k = cyc;
        last_rx = k;
        bus.rx_en = 1'b1; bus.check_crc = cc; bus.check_index = ci; bus.exp_index = ei;
        bus.sd_cmd = 1'b1;
        prev_content = exp_content;
        b_lo = k + 1;
        if (dly >= T) begin
            b_hi = k + T + 1;
            done_cyc = k + T + 1;
            exp_flags = 4'b1000;
        end else begin
            s = k + 1 + dly;
            b_hi = s + 48;
            done_cyc = s + 48;
            exp_flags = {1'b0, cc && (f[7:1] != crc7(f[47:8])), f[46] | ~f[0],
                         ci && (f[45:40] != ei)};
            exp_content = f[45:8];
        end
        tick();
        bus.rx_en = 1'b0;
        bus.check_crc = 1'($urandom); bus.check_index = 1'($urandom);
        bus.exp_index = 6'($urandom);
        if (dly >= T) begin
            while (cyc < done_cyc) tick();
        end else begin
            repeat (dly) tick();
            for (int i = 47; i >= 0; i--) begin
                bus.sd_cmd = f[i];
                bus.rx_en = rx_mid && (i == 30);
                if (i == abort_bit) begin
                    b_lo = -10; b_hi = -10; done_cyc = -10;
                    exp_content = '0; prev_content = '0; exp_flags = '0;
                    reset = 1'b1;
                    tick();
                    reset = 1'b0;
                    bus.sd_cmd = 1'b1;
                    bus.rx_en = 1'b0;
                    return;
                end
                tick();
            end
            bus.sd_cmd = 1'b1;
            bus.rx_en = 1'b0;
        end
        bus.rx_en = rx_at_done;
        tick();
        bus.rx_en = 1'b0;
        repeat ($urandom_range(0, 3)) begin
            bus.sd_cmd = 1'($urandom);
            tick();
        end
        bus.sd_cmd = 1'b1;
    endtask

    localparam logic [47:0] F1 = 48'h08_00_00_01_AA_13;

    initial begin
        logic [47:0] f;
        int dly;
        logic [5:0] idx;
        reset = 1'b1;
        bus.rx_en = 1'b0; bus.sd_cmd = 1'b1; bus.check_crc = 1'b0;
        bus.check_index = 1'b0; bus.exp_index = '0;
        repeat (3) tick();
        mon_on = 1'b1;
        chk("reset_outputs", 64'({bus.resp_content, bus.busy, bus.done, flags()}), 64'd0);
        reset = 1'b0;
        tick();

        chk("model_crc_cmd8", 64'(crc7(40'h08_000001AA)), 64'h09);

        // 1) CMD8 R7 good frame, start bit right after arming
        run(F1, 0, 1, 1, 6'd8, -1, 0, 0);
        chk("t1_latency", 64'(done_seen - last_rx), 64'd49);
        chk("t1_content", 64'(bus.resp_content), 64'h08_000001AA);
        chk("t1_flags", 64'(flags()), 64'd0);
        // 2) bad CRC, then same with CRC check off
        run(48'h08_00_00_01_AA_15, 5, 1, 1, 6'd8, -1, 0, 1);
        chk("t2_crc_err", 64'(flags()), 64'b0100);
        chk("t2_content", 64'(bus.resp_content), 64'h08_000001AA);
        run(48'h08_00_00_01_AA_15, 2, 0, 1, 6'd8, -1, 0, 0);
        chk("t2_crc_off", 64'(flags()), 64'b0000);
        // 3) index mismatch
        run(F1, 1, 1, 1, 6'd55, -1, 0, 0);
        chk("t3_index_err", 64'(flags()), 64'b0001);
        // 4) timeout keeps previous content
        run(F1, T + 5, 1, 1, 6'd8, -1, 0, 0);
        chk("t4_latency", 64'(done_seen - last_rx), 64'(T + 1));
        chk("t4_flags", 64'(flags()), 64'b1000);
        chk("t4_content", 64'(bus.resp_content), 64'h08_000001AA);
        // 5) start bit on the last timer cycle; bad end bit; bad transmission bit
        run(F1, T - 1, 1, 1, 6'd8, -1, 0, 0);
        chk("t5_last_start", 64'(flags()), 64'b0000);
        run(48'h08_00_00_01_AA_12, 0, 1, 1, 6'd8, -1, 0, 0);
        chk("t5_end_bit", 64'(bus.frame_err), 64'd1);
        run(48'h48_00_00_01_AA_13, 0, 0, 0, 6'd8, -1, 0, 0);
        chk("t5_tx_bit", 64'(flags()), 64'b0010);
        run(48'h0, 0, 1, 0, 6'd8, -1, 0, 0);
        chk("stuck_low", 64'(flags()), 64'b0010);
        // 6) reset mid-frame, then clean frame; rx_en mid-frame ignored
        run(F1, 3, 1, 1, 6'd8, 20, 0, 0);
        chk("t6_after_reset", 64'({bus.resp_content, bus.busy, bus.done, flags()}), 64'd0);
        run(F1, 3, 1, 1, 6'd8, -1, 1, 0);
        chk("t6_clean", 64'({bus.resp_content, flags()}), {22'd0, 38'h08_000001AA, 4'b0000});

        for (int n = 0; n < 40; n++) begin
            idx = 6'($urandom);
            f = mk(idx, $urandom);
            case ($urandom_range(0, 9))
                0: f[7:1] = f[7:1] ^ 7'($urandom_range(1, 127));
                1: f[0] = 1'b0;
                2: f[46] = 1'b1;
                3: f = '0;
                default: ;
            endcase
            dly = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, T + 3);
            run(f, dly, 1'($urandom), 1'($urandom),
                ($urandom_range(0, 2) == 0) ? 6'($urandom) : idx,
                ($urandom_range(0, 11) == 0) ? $urandom_range(1, 46) : -1,
                1'($urandom), 1'($urandom));
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
